// File: rtl/tile_map_arbiter.sv
// -----------------------------------------------------------------------------
// tile_map_arbiter
//
// Owns the single-port working tile map (MAP_W x MAP_H entries, 4 bits each)
// and shares it between the VGA renderer (absolute priority) and N_REQ
// game-logic requesters (served round-robin). It also reloads the map from the
// original-map ROM after reset and whenever a restart is requested.
//
// Ports:
//   VGA_CLK    in   clock
//   reset      in   synchronous, active-low reset
//   vid_req    in   renderer read request (one cycle per tile fetch)
//   vid_addr   in   renderer tile address
//   vid_data   out  renderer read data (one cycle after vid_req)
//   vid_valid  out  vid_data valid
//   req        in   per-requester access request (level)
//   we         in   per-requester write enable (1 = write, 0 = read)
//   addr       in   packed requester addresses, slice i for requester i
//   wdata      in   packed requester write data, slice i for requester i
//   ack        out  one-cycle completion pulse per requester
//   rdata      out  read data for the acked requester (holds on write acks)
//   restore    in   restart pulse: reload the map from ROM
//   busy       out  restore in progress
//   rom_addr   out  original-map ROM address
//   rom_data   in   ROM data, combinational with respect to rom_addr
// -----------------------------------------------------------------------------
module tile_map_arbiter #(
   parameter int         N_REQ     = 3,
   parameter int         MAP_W     = 40,
   parameter int         MAP_H     = 30,
   parameter int         ADDR_W    = 11,
   parameter logic [3:0] WALL_CODE = 4'd1
) (
   input  logic                      VGA_CLK,
   input  logic                      reset,
   input  logic                      vid_req,
   input  logic [ADDR_W-1:0]         vid_addr,
   output logic [3:0]                vid_data,
   output logic                      vid_valid,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          we,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   input  logic [N_REQ*4-1:0]        wdata,
   output logic [N_REQ-1:0]          ack,
   output logic [3:0]                rdata,
   input  logic                      restore,
   output logic                      busy,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [3:0]                rom_data
);

   localparam int DEPTH = MAP_W * MAP_H;
   localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_RESTORE = 1'b0,
      ST_SERVE   = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t             r_state;
   logic [ADDR_W-1:0]  r_ri;
   logic [RR_W-1:0]    r_rr;
   logic               r_vid_valid;
   logic               r_vid_oor;
   logic [N_REQ-1:0]   r_ack;
   logic               r_ack_rd;
   logic               r_ack_oor;
   logic [3:0]         r_rdata_hold;

   // Map storage with a registered read port
   logic [3:0]         r_map [DEPTH];
   logic [3:0]         r_rd_q;

   // -------------------------------------------------------------------------
   // Next-state signals
   // -------------------------------------------------------------------------
   state_t             w_state_next;
   logic [ADDR_W-1:0]  w_ri_next;
   logic [RR_W-1:0]    w_rr_next;
   logic               w_ram_we;
   logic               w_ram_re;
   logic [ADDR_W-1:0]  w_ram_addr;
   logic [3:0]         w_ram_wdata;
   logic               w_do_grant;
   logic [N_REQ-1:0]   w_ack_next;
   logic               w_vid_inr;
   logic               w_gnt_vld;
   logic [RR_W-1:0]    w_gnt_idx;
   logic [ADDR_W-1:0]  w_gnt_addr;
   logic [3:0]         w_gnt_wdata;
   logic               w_gnt_we;
   logic               w_gnt_inr;
   logic [3:0]         w_rdata;

   // Unpack the per-requester address and data slices
   logic [ADDR_W-1:0]  w_addr_arr  [N_REQ];
   logic [3:0]         w_wdata_arr [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
         assign w_wdata_arr[gi] = wdata[gi*4 +: 4];
      end
   endgenerate

   // Range checks use one extra bit so DEPTH itself is always representable
   assign w_vid_inr = ({1'b0, vid_addr} < (ADDR_W+1)'(DEPTH));

   // -------------------------------------------------------------------------
   // Round-robin pick: first requester at or after r_rr, wrapping around
   // -------------------------------------------------------------------------
   always_comb begin
      logic [RR_W:0] v_sum;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      v_sum     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         v_sum = {1'b0, r_rr} + (RR_W+1)'(k);
         if (v_sum >= (RR_W+1)'(N_REQ)) begin
            v_sum = v_sum - (RR_W+1)'(N_REQ);
         end
         if (!w_gnt_vld && req[v_sum[RR_W-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = v_sum[RR_W-1:0];
         end
      end
   end

   assign w_gnt_addr  = w_addr_arr[w_gnt_idx];
   assign w_gnt_wdata = w_wdata_arr[w_gnt_idx];
   assign w_gnt_we    = we[w_gnt_idx];
   assign w_gnt_inr   = ({1'b0, w_gnt_addr} < (ADDR_W+1)'(DEPTH));

   // -------------------------------------------------------------------------
   // Next-state and RAM port control
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_ri_next    = r_ri;
      w_rr_next    = r_rr;
      w_ram_we     = 1'b0;
      w_ram_re     = 1'b0;
      w_ram_addr   = r_ri;
      w_ram_wdata  = rom_data;
      w_do_grant   = 1'b0;

      case (r_state)
         ST_RESTORE: begin
            if (vid_req) begin
               // Renderer steals the port; the restore index holds
               w_ram_addr = vid_addr;
               w_ram_re   = w_vid_inr;
            end else begin
               w_ram_we = 1'b1;
               if (r_ri == LAST_ADDR) begin
                  w_state_next = ST_SERVE;
                  w_ri_next    = '0;
               end else begin
                  w_ri_next = r_ri + 1'b1;
               end
            end
            if (restore) begin
               w_state_next = ST_RESTORE;
               w_ri_next    = '0;
            end
         end

         default: begin  // ST_SERVE
            if (vid_req) begin
               w_ram_addr = vid_addr;
               w_ram_re   = w_vid_inr;
            end else if (w_gnt_vld) begin
               w_do_grant  = 1'b1;
               w_ram_addr  = w_gnt_addr;
               w_ram_wdata = w_gnt_wdata;
               // Out-of-range accesses never touch the array but are still acked
               w_ram_we    = w_gnt_we & w_gnt_inr;
               w_ram_re    = ~w_gnt_we & w_gnt_inr;
               w_rr_next   = (w_gnt_idx == RR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (restore) begin
               w_state_next = ST_RESTORE;
               w_ri_next    = '0;
            end
         end
      endcase

      // A write issued in a reset cycle must not land in the map
      if (!reset) begin
         w_ram_we = 1'b0;
      end
   end

   assign w_ack_next = w_do_grant ? (N_REQ'(1) << w_gnt_idx) : '0;

   // -------------------------------------------------------------------------
   // Map RAM (single port, registered read, no reset on the array)
   // -------------------------------------------------------------------------
   always_ff @(posedge VGA_CLK) begin
      if (w_ram_we) begin
         r_map[w_ram_addr] <= w_ram_wdata;
      end
      if (w_ram_re) begin
         r_rd_q <= r_map[w_ram_addr];
      end
   end

   // -------------------------------------------------------------------------
   // Control registers
   // -------------------------------------------------------------------------
   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         r_state      <= ST_RESTORE;
         r_ri         <= '0;
         r_rr         <= '0;
         r_vid_valid  <= 1'b0;
         r_vid_oor    <= 1'b0;
         r_ack        <= '0;
         r_ack_rd     <= 1'b0;
         r_ack_oor    <= 1'b0;
         r_rdata_hold <= 4'd0;
      end else begin
         r_state      <= w_state_next;
         r_ri         <= w_ri_next;
         r_rr         <= w_rr_next;
         r_vid_valid  <= vid_req;
         r_vid_oor    <= ~w_vid_inr;
         r_ack        <= w_ack_next;
         r_ack_rd     <= w_do_grant & ~w_gnt_we;
         r_ack_oor    <= ~w_gnt_inr;
         r_rdata_hold <= w_rdata;
      end
   end

   // rdata follows the RAM only in a read-ack cycle and otherwise holds
   assign w_rdata = ((|r_ack) && r_ack_rd) ? (r_ack_oor ? WALL_CODE : r_rd_q)
                                           : r_rdata_hold;

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign rdata     = w_rdata;
   assign ack       = r_ack;
   assign vid_valid = r_vid_valid;
   assign vid_data  = r_vid_valid ? (r_vid_oor ? WALL_CODE : r_rd_q) : 4'd0;
   assign busy      = (r_state == ST_RESTORE);
   assign rom_addr  = r_ri;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tile_map_arbiter
//
// Scoreboard bench for tile_map_arbiter. Expected video data and game acks are
// queued when stimulus is driven and compared by a monitor when the design
// produces vid_valid or ack. The ROM model returns address % 9.
// -----------------------------------------------------------------------------
module tb_tile_map_arbiter;

   localparam int N_REQ  = 3;
   localparam int MAP_W  = 40;
   localparam int MAP_H  = 30;
   localparam int ADDR_W = 11;
   localparam int WALL   = 1;

   logic                    VGA_CLK = 1'b0;
   logic                    reset;
   logic                    vid_req;
   logic [ADDR_W-1:0]       vid_addr;
   logic [3:0]              vid_data;
   logic                    vid_valid;
   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        we;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ*4-1:0]      wdata;
   logic [N_REQ-1:0]        ack;
   logic [3:0]              rdata;
   logic                    restore;
   logic                    busy;
   logic [ADDR_W-1:0]       rom_addr;
   logic [3:0]              rom_data;

   always #5 VGA_CLK = ~VGA_CLK;

   // Original-map ROM model
   always_comb rom_data = 4'(rom_addr % 9);

   tile_map_arbiter #(
      .N_REQ     (N_REQ),
      .MAP_W     (MAP_W),
      .MAP_H     (MAP_H),
      .ADDR_W    (ADDR_W),
      .WALL_CODE (4'd1)
   ) dut (
      .VGA_CLK   (VGA_CLK),
      .reset     (reset),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .restore   (restore),
      .busy      (busy),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Scoreboard queues
   string vid_tag_q[$];
   int    vid_dat_q[$];
   string gm_tag_q[$];
   int    gm_idx_q[$];
   int    gm_dat_q[$];   // -1 marks a write (rdata must hold)
   int    last_rd = 0;

   // Monitor: compares design outputs against the scoreboard
   always @(negedge VGA_CLK) begin
      if (reset) begin
         if (vid_valid) begin
            if (vid_tag_q.size() == 0) begin
               check_val("vid_unexpected", 1, 0);
            end else begin
               check_val(vid_tag_q.pop_front(), 32'(vid_data), vid_dat_q.pop_front());
            end
         end
         if (ack != '0) begin
            if (gm_tag_q.size() == 0) begin
               check_val("ack_unexpected", 32'(ack), 0);
            end else begin
               string t;
               int    ix;
               int    d;
               t  = gm_tag_q.pop_front();
               ix = gm_idx_q.pop_front();
               d  = gm_dat_q.pop_front();
               check_val({t, "_ack"}, 32'(ack), 32'(1) << ix);
               check_val({t, "_rdata"}, 32'(rdata), (d < 0) ? last_rd : d);
               if (d >= 0) last_rd = d;
            end
            // Requester drops its request in the cycle it sees ack
            req = req & ~ack;
         end
      end
   end

   task automatic vid_read(input int a, input int exp, input string tag);
      vid_req  = 1'b1;
      vid_addr = ADDR_W'(a);
      vid_tag_q.push_back(tag);
      vid_dat_q.push_back(exp);
      @(negedge VGA_CLK); #1;
      vid_req = 1'b0;
   endtask

   task automatic game(input int i, input bit w, input int a, input int d, input string tag);
      addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
      wdata[i*4 +: 4]          = 4'(d);
      we[i]                    = w;
      req[i]                   = 1'b1;
      gm_tag_q.push_back(tag);
      gm_idx_q.push_back(i);
      gm_dat_q.push_back(w ? -1 : d);
   endtask

   task automatic wait_done(input int budget, input string tag, output int cnt);
      cnt = 0;
      while ((req != '0 || gm_tag_q.size() != 0) && cnt < budget) begin
         @(negedge VGA_CLK); #1;
         cnt++;
      end
      if (req != '0 || gm_tag_q.size() != 0) begin
         check_val({tag, "_timeout"}, 1, 0);
         req = '0;
         gm_tag_q.delete();
         gm_idx_q.delete();
         gm_dat_q.delete();
      end
   endtask

   initial begin
      int  cnt;
      bit  ack_in_busy;
      reset    = 1'b0;
      vid_req  = 1'b0;
      vid_addr = '0;
      req      = '0;
      we       = '0;
      addr     = '0;
      wdata    = '0;
      restore  = 1'b0;

      // Reset held for two edges
      repeat (2) @(posedge VGA_CLK);
      @(negedge VGA_CLK);
      check_val("rst_ack",       32'(ack),       0);
      check_val("rst_vid_valid", 32'(vid_valid), 0);
      check_val("rst_vid_data",  32'(vid_data),  0);
      check_val("rst_rdata",     32'(rdata),     0);
      check_val("rst_busy",      32'(busy),      1);
      check_val("rst_rom_addr",  32'(rom_addr),  0);
      reset = 1'b1;

      // Initial restore length
      cnt = 0;
      while (busy && cnt < 2000) begin
         cnt++;
         @(negedge VGA_CLK);
      end
      #1;
      check_val("busy_len", cnt, 1200);

      // Read-back of restored contents (also walks rr back to 0)
      game(0, 1'b0, 0, 0, "rd_0");
      wait_done(10, "rd_0", cnt);
      game(1, 1'b0, 41, 5, "rd_41");
      wait_done(10, "rd_41", cnt);
      game(2, 1'b0, 1199, 2, "rd_1199");
      wait_done(10, "rd_1199", cnt);

      // Single video fetch, then vid_valid must drop
      vid_read(17, 8, "vid_17");
      @(negedge VGA_CLK); #1;
      check_val("vid_valid_drop", 32'(vid_valid), 0);
      vid_read(1500, WALL, "vid_oor");
      @(negedge VGA_CLK); #1;

      // Round robin: all three reads raised together
      game(0, 1'b0, 5,   5, "rr_0");
      game(1, 1'b0, 52,  7, "rr_1");
      game(2, 1'b0, 300, 3, "rr_2");
      wait_done(10, "rr", cnt);
      check_val("rr_cycles", cnt, 3);

      // Video priority starves a pending write for five cycles
      vid_req  = 1'b1;
      vid_addr = ADDR_W'(17);
      game(0, 1'b1, 600, 4, "wr_600");
      for (int c = 0; c < 5; c++) begin
         vid_tag_q.push_back("vid_starve");
         vid_dat_q.push_back(8);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge VGA_CLK); #1;
         check_val("starve_noack", 32'(ack), 0);
      end
      vid_req = 1'b0;
      wait_done(5, "wr_600", cnt);
      check_val("wr_600_latency", cnt, 1);
      vid_read(600, 4, "vid_600");
      @(negedge VGA_CLK); #1;

      // Out-of-range game accesses
      game(1, 1'b0, 1200, WALL, "rd_oor");
      wait_done(10, "rd_oor", cnt);
      game(1, 1'b1, 1250, 7, "wr_oor");
      wait_done(10, "wr_oor", cnt);
      vid_read(226, 1, "vid_226_alias");
      vid_read(1250, WALL, "vid_1250");
      @(negedge VGA_CLK); #1;

      // Overwrite, then restart restores the original contents
      game(2, 1'b1, 100, 0, "wr_100");
      wait_done(10, "wr_100", cnt);
      vid_read(100, 0, "vid_100_pre");
      @(negedge VGA_CLK); #1;
      restore = 1'b1;
      @(negedge VGA_CLK); #1;
      restore = 1'b0;
      check_val("restore_busy", 32'(busy), 1);
      game(2, 1'b0, 100, 1, "rd_100_post");
      cnt = 0;
      ack_in_busy = 1'b0;
      while (busy && cnt < 1500) begin
         cnt++;
         if (ack != '0) ack_in_busy = 1'b1;
         @(negedge VGA_CLK); #1;
      end
      check_val("restore_busy_len", cnt, 1200);
      check_val("restore_noack", 32'(ack_in_busy), 0);
      wait_done(10, "rd_100_post", cnt);

      // Anything still queued was never produced by the design
      check_val("vid_q_empty", vid_tag_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
